// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout engine (master) and the synchronous
// pixel RAM (slave). Read data is valid one clock after fb_addr/fb_rd.
interface vga_scanout_if;
  logic [16:0] fb_addr;
  logic        fb_rd;
  logic [2:0]  fb_data;

  modport master (
    output fb_addr,
    output fb_rd,
    input  fb_data
  );

  modport slave (
    input  fb_addr,
    input  fb_rd,
    output fb_data
  );
endinterface

// File: rtl/vga_scanout.sv
// Scans a 320x240 3-bit framebuffer out as 640x480@60 VGA with 2x2 pixel doubling,
// a /2 pixel enable derived from the 50 MHz clock, and a once-per-frame tick.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.master fb,
  output logic          vga_clk_o,
  output logic          vga_hs_o,
  output logic          vga_vs_o,
  output logic          vga_blank_n_o,
  output logic          vga_sync_n_o,
  output logic [7:0]    vga_r_o,
  output logic [7:0]    vga_g_o,
  output logic [7:0]    vga_b_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST_C     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_C      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST_C   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST_C    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST_C   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST_C    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic        pix_en_q;
  logic        pix_en_d;
  logic [9:0]  h_q;
  logic [9:0]  h_d;
  logic [9:0]  v_q;
  logic [9:0]  v_d;
  logic        hs_q;
  logic        hs_d;
  logic        vs_q;
  logic        vs_d;
  logic        blank_n_q;
  logic        blank_n_d;
  logic [7:0]  r_q;
  logic [7:0]  r_d;
  logic [7:0]  g_q;
  logic [7:0]  g_d;
  logic [7:0]  b_q;
  logic [7:0]  b_d;
  logic        frame_start_q;
  logic        frame_start_d;

  logic        visible_s;
  logic [8:0]  x_s;
  logic [8:0]  y_s;
  logic [16:0] lin_addr_s;

  // State register: every register returns to its idle value on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en_q      <= 1'b0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      b_q           <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Raster counters step once per 2-clock pixel period.
  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_q) begin
      if (h_q == H_LAST_C) begin
        h_d = 10'd0;
        if (v_q == V_LAST_C) begin
          v_d = 10'd0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
        v_d = v_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // y*320 as (y<<8)+(y<<6); dropping bit 0 of each counter doubles every pixel.
  always_comb begin
    visible_s  = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    x_s        = h_q[9:1];
    y_s        = v_q[9:1];
    lin_addr_s = ({8'd0, y_s} << 8) + ({8'd0, y_s} << 6) + {8'd0, x_s};
    if (visible_s) begin
      fb.fb_addr = lin_addr_s;
      fb.fb_rd   = 1'b1;
    end else begin
      fb.fb_addr = 17'd0;
      fb.fb_rd   = 1'b0;
    end
  end

  // DAC stage samples on the second clock of the pixel, when fb_data for it is valid.
  always_comb begin
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    frame_start_d = pix_en_q && (h_q == H_LAST_C) && (v_q == V_LAST_C);
    if (pix_en_q) begin
      hs_d      = ~((h_q >= HS_FIRST_C) && (h_q <= HS_LAST_C));
      vs_d      = ~((v_q >= VS_FIRST_C) && (v_q <= VS_LAST_C));
      blank_n_d = visible_s;
      if (visible_s) begin
        r_d = {8{fb.fb_data[2]}};
        g_d = {8{fb.fb_data[1]}};
        b_d = {8{fb.fb_data[0]}};
      end else begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
      end
    end else begin
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
    end
  end

  assign vga_clk_o     = pix_en_q;
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign vga_blank_n_o = blank_n_q;
  assign vga_sync_n_o  = 1'b1;
  assign vga_r_o       = r_q;
  assign vga_g_o       = g_q;
  assign vga_b_o       = b_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench: instance A uses full 640x480 timing for line-level checks,
// instance B a 14-pixel line so whole frames (525 lines) fit in a short run.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a;
  logic rst_b;
  longint gcount = 0;
  int checks = 0;
  int errors = 0;

  vga_scanout_if fb_a ();
  vga_scanout_if fb_b ();

  logic a_vclk, a_hs, a_vs, a_bl, a_sn, a_fs;
  logic [7:0] a_r, a_g, a_b;
  logic b_vclk, b_hs, b_vs, b_bl, b_sn, b_fs;
  logic [7:0] b_r, b_g, b_b;

  vga_scanout dut_a (
    .clk(clk), .rst(rst_a), .fb(fb_a.master),
    .vga_clk_o(a_vclk), .vga_hs_o(a_hs), .vga_vs_o(a_vs), .vga_blank_n_o(a_bl),
    .vga_sync_n_o(a_sn), .vga_r_o(a_r), .vga_g_o(a_g), .vga_b_o(a_b),
    .frame_start_o(a_fs)
  );

  vga_scanout #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33)
  ) dut_b (
    .clk(clk), .rst(rst_b), .fb(fb_b.master),
    .vga_clk_o(b_vclk), .vga_hs_o(b_hs), .vga_vs_o(b_vs), .vga_blank_n_o(b_bl),
    .vga_sync_n_o(b_sn), .vga_r_o(b_r), .vga_g_o(b_g), .vga_b_o(b_b),
    .frame_start_o(b_fs)
  );

  // Synchronous RAM models holding memory[a] = a mod 8.
  always @(posedge clk) begin
    if (fb_a.fb_rd) fb_a.fb_data <= fb_a.fb_addr[2:0];
    if (fb_b.fb_rd) fb_b.fb_data <= fb_b.fb_addr[2:0];
  end

  always @(posedge clk) gcount <= gcount + 1;

  wire logic [47:0] obs_a = {a_fs, a_vclk, a_sn, fb_a.fb_rd, fb_a.fb_addr,
                             a_hs, a_vs, a_bl, a_r, a_g, a_b};
  wire logic [47:0] obs_b = {b_fs, b_vclk, b_sn, fb_b.fb_rd, fb_b.fb_addr,
                             b_hs, b_vs, b_bl, b_r, b_g, b_b};

  typedef struct {
    longint      at;
    bit          inst;
    string       name;
    logic [47:0] exp;
    logic [47:0] mask;
  } item_t;

  item_t q[$];

  localparam logic [47:0] M_OUT  = {21'd0, 3'b111, 24'hFFFFFF};
  localparam logic [47:0] M_ADDR = {3'd0, 1'b1, 17'h1FFFF, 27'd0};
  localparam logic [47:0] M_MISC = {3'b111, 45'd0};
  localparam logic [47:0] M_ALL  = {48{1'b1}};

  function automatic logic [47:0] f_out(input logic hs, input logic vs, input logic bl,
                                        input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    return {21'd0, hs, vs, bl, r, g, b};
  endfunction

  function automatic logic [47:0] f_addr(input logic rd, input logic [16:0] addr);
    return {3'd0, rd, addr, 27'd0};
  endfunction

  function automatic logic [47:0] f_misc(input logic fs, input logic vclk);
    return {fs, vclk, 1'b1, 45'd0};
  endfunction

  task automatic push(input bit inst, input longint at, input string nm,
                      input logic [47:0] e, input logic [47:0] m);
    item_t it;
    it.at = at; it.inst = inst; it.name = nm; it.exp = e; it.mask = m;
    q.push_back(it);
  endtask

  task automatic chk_out(input bit inst, input longint at, input string nm,
                         input logic hs, input logic vs, input logic bl,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    push(inst, at, nm, f_out(hs, vs, bl, r, g, b), M_OUT);
  endtask

  task automatic chk_addr(input bit inst, input longint at, input string nm,
                          input logic rd, input logic [16:0] addr);
    push(inst, at, nm, f_addr(rd, addr), M_ADDR);
  endtask

  task automatic chk_misc(input bit inst, input longint at, input string nm,
                          input logic fs, input logic vclk);
    push(inst, at, nm, f_misc(fs, vclk), M_MISC);
  endtask

  task automatic chk_reset(input bit inst, input longint at, input string nm);
    push(inst, at, nm,
         f_misc(1'b0, 1'b0) | f_addr(1'b1, 17'd0) |
         f_out(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00), M_ALL);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) @(posedge clk);
  endtask

  // Monitor: compares every due expectation on the falling edge.
  always @(negedge clk) begin
    item_t it;
    logic [47:0] obs;
    while (q.size() > 0 && q[0].at <= gcount) begin
      it  = q.pop_front();
      obs = it.inst ? obs_b : obs_a;
      checks = checks + 1;
      if (it.at != gcount) begin
        errors = errors + 1;
        $display("FAIL %s: due at cycle %0d, not sampled before %0d", it.name, it.at, gcount);
      end else if (((obs ^ it.exp) & it.mask) !== 48'd0) begin
        errors = errors + 1;
        $display("FAIL %s: got %h required %h (mask %h)", it.name,
                 obs & it.mask, it.exp & it.mask, it.mask);
      end
    end
  end

  initial begin
    longint base;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);

    // ---- Instance A: full 640x480 timing, first lines only ----
    #1 rst_a = 1'b0;
    base = gcount;
    chk_reset(0, base + 0, "a_reset_state");
    chk_misc (0, base + 1, "a_vclk_rise", 1'b0, 1'b1);
    chk_out  (0, base + 1, "a_hold_before_first_pixel", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_misc (0, base + 2, "a_vclk_fall", 1'b0, 1'b0);
    chk_out  (0, base + 2, "a_first_pixel_addr0", 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_addr (0, base + 4, "a_px2_addr", 1'b1, 17'd1);
    chk_addr (0, base + 6, "a_px3_addr", 1'b1, 17'd1);
    chk_out  (0, base + 6, "a_px2_blue", 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
    chk_addr (0, base + 8, "a_px4_addr", 1'b1, 17'd2);
    chk_out  (0, base + 18, "a_px8_red", 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    chk_out  (0, base + 20, "a_px9_red", 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    chk_out  (0, base + 30, "a_px14_white", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_addr (0, base + 1278, "a_px639_addr", 1'b1, 17'd319);
    chk_addr (0, base + 1280, "a_px640_no_read", 1'b0, 17'd0);
    chk_out  (0, base + 1280, "a_px639_white", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_out  (0, base + 1282, "a_px640_blank", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_out  (0, base + 1312, "a_px655_hs_high", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_out  (0, base + 1314, "a_px656_hs_low", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_out  (0, base + 1504, "a_px751_hs_low", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_out  (0, base + 1506, "a_px752_hs_high", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_addr (0, base + 1600, "a_line1_addr", 1'b1, 17'd0);
    chk_out  (0, base + 1602, "a_line1_visible", 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_addr (0, base + 3200, "a_line2_addr", 1'b1, 17'd320);
    chk_out  (0, base + 3206, "a_line2_px2_blue", 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
    chk_addr (0, base + 4800, "a_line3_addr", 1'b1, 17'd320);
    chk_addr (0, base + 6400, "a_line4_addr", 1'b1, 17'd640);
    drain(8000);
    rst_a = 1'b1;

    // ---- Instance B: 14-pixel lines, full 525-line frames ----
    @(posedge clk);
    #1 rst_b = 1'b0;
    base = gcount;
    chk_reset(1, base + 0, "b_reset_state");
    chk_addr (1, base + 13426, "b_px7_479_addr", 1'b1, 17'd76483);
    chk_addr (1, base + 13428, "b_px8_479_no_read", 1'b0, 17'd0);
    chk_out  (1, base + 13428, "b_px7_479_cyan", 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF);
    chk_out  (1, base + 13720, "b_line489_vs_high", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_out  (1, base + 13722, "b_line490_vs_low", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_out  (1, base + 13776, "b_line491_vs_low", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_out  (1, base + 13778, "b_line492_vs_high", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_misc (1, base + 14699, "b_fs_before", 1'b0, 1'b1);
    chk_misc (1, base + 14700, "b_fs_pulse", 1'b1, 1'b0);
    chk_addr (1, base + 14700, "b_frame_wrap_addr", 1'b1, 17'd0);
    chk_misc (1, base + 14701, "b_fs_after", 1'b0, 1'b1);
    chk_addr (1, base + 20310, "b_midframe_addr", 1'b1, 17'd32002);
    chk_out  (1, base + 20310, "b_midframe_green", 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
    chk_reset(1, base + 20311, "b_async_reset");
    do begin
      @(posedge clk);
      #1;
    end while (gcount < base + 20311);
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    base = gcount;
    chk_reset(1, base + 0, "b_release_state");
    chk_misc (1, base + 1, "b_no_fs_from_reset", 1'b0, 1'b1);
    chk_out  (1, base + 2, "b_restart_first_pixel", 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_misc (1, base + 14699, "b_fs2_before", 1'b0, 1'b1);
    chk_misc (1, base + 14700, "b_fs2_pulse", 1'b1, 1'b0);
    chk_misc (1, base + 14701, "b_fs2_after", 1'b0, 1'b1);
    drain(16000);

    if (q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
